ahbl_sram_responder: RTL and testbench

- AHB-Lite subordinate (responder) that serves a single-ported synchronous SRAM. It is the far end of the core's single AHB-Lite manager port, and the default target for instruction and data in small Hazard5 systems.
- Reads are zero-wait-state by default. Writes are posted through a one-entry write buffer, so a read issued in a write's data phase does not stall.
- Illegal transfers get the standard two-cycle AHB ERROR response.

---
 rtl/ahbl_sram_responder_pkg.sv | 44 ++++
 rtl/ahbl_sram_responder_if.sv | 32 +++
 rtl/ahbl_sram_wbuf.sv | 48 ++++
 rtl/ahbl_sram_responder.sv | 144 ++++++++++++++
 tb/tb_ahbl_sram_responder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_sram_responder_pkg.sv
// Shared constants, FSM state type and address-phase helpers for the
// AHB-Lite SRAM responder.
package ahbl_sram_responder_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPH  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Byte lanes touched by a transfer of the given size at the given offset.
  function automatic logic [3:0] byte_mask(input logic [1:0] addr, input logic [2:0] size);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = 4'b1111;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

  // Oversized or misaligned transfers are answered with ERROR.
  function automatic logic size_addr_err(input logic [1:0] addr, input logic [2:0] size);
    logic e;
    e = 1'b0;
    if (size > HSIZE_WORD)                    e = 1'b1;
    else if (size == HSIZE_HALF && addr[0])   e = 1'b1;
    else if (size == HSIZE_WORD && addr != 0) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/ahbl_sram_responder_if.sv
// AHB-Lite subordinate-side bus bundle for the SRAM responder.
//
// Handshake: a transfer is accepted in its address phase when
// hsel && htrans[1] && hready are all high on a rising edge. Its data phase
// completes on the first rising edge where hready_resp is high; until then the
// manager holds the next address phase and hwdata stable. hresp qualifies the
// completing data phase (1 = ERROR, which always spans two cycles).
interface ahbl_sram_responder_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              hready;
  logic              hready_resp;
  logic              hresp;
  logic              hsel;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;

  modport slave (
    input  hready, hsel, haddr, hwrite, htrans, hsize, hwdata,
    output hready_resp, hresp, hrdata
  );

  modport master (
    input  hready, hready_resp, hresp, hrdata,
    output hsel, haddr, hwrite, htrans, hsize, hwdata
  );
endinterface

// File: rtl/ahbl_sram_wbuf.sv
// One-entry posted-write buffer with read-after-write forwarding.
module ahbl_sram_wbuf #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [3:0]    fill_mask,
  input  logic [31:0]   fill_data,
  input  logic          flush,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [3:0]    mask,
  output logic [31:0]   data,
  input  logic [AW-1:0] fwd_addr,
  input  logic [31:0]   fwd_rdata,
  output logic [31:0]   fwd_data
);

  // Entry storage: a fill in the same cycle as a flush leaves the new entry valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      mask  <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      addr  <= fill_addr;
      mask  <= fill_mask;
      data  <= fill_data;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

  // Merge buffered bytes over SRAM read data when the word addresses match.
  always_comb begin
    fwd_data = fwd_rdata;
    if (valid && addr == fwd_addr) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) fwd_data[8*b +: 8] = data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite responder in front of a single-ported synchronous SRAM.
// Reads go to the SRAM in their address phase; writes are posted through a
// one-entry buffer that drains whenever the SRAM port is otherwise free.
module ahbl_sram_responder
  import ahbl_sram_responder_pkg::*;
#(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  ahbl_sram_responder_if.slave  ahbls,
  output logic [AW-1:0]         sram_addr,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [3:0]            sram_wmask,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata,
  output state_t                dbg_state
);

  state_t        state, state_nxt;
  logic [2:0]    wait_cnt, wait_cnt_nxt;
  logic          dph_write;
  logic [AW-1:0] dph_addr;
  logic [3:0]    dph_mask;

  logic          aph_req, aph_err, aph_valid, aph_ok;
  logic          rd_req, rd_accept;
  logic [AW-1:0] aph_addr;
  logic          hready_resp, hresp, stall, reread;
  logic          wb_fill, wb_flush, wb_valid;
  logic [AW-1:0] wb_addr;
  logic [3:0]    wb_mask;
  logic [31:0]   wb_data, fwd_data;
  logic          unused_bits;

  // Address-phase decode; upper address bits alias onto the word index.
  assign aph_req   = ahbls.hsel && ahbls.htrans[1] && !rst;
  assign aph_err   = size_addr_err(ahbls.haddr[1:0], ahbls.hsize);
  assign aph_valid = aph_req && ahbls.hready;
  assign aph_ok    = aph_valid && !aph_err;
  assign aph_addr  = ahbls.haddr[AW+1:2];
  assign rd_req    = aph_req && !ahbls.hwrite && !aph_err;
  assign rd_accept = rd_req && ahbls.hready;

  assign unused_bits = ^{ahbls.haddr[W_ADDR-1:AW+2], ahbls.htrans[0]};

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Data-phase bookkeeping captured when an OKAY transfer is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dph_write <= 1'b0;
      dph_addr  <= '0;
      dph_mask  <= '0;
    end else if (aph_ok) begin
      dph_write <= ahbls.hwrite;
      dph_addr  <= aph_addr;
      dph_mask  <= byte_mask(ahbls.haddr[1:0], ahbls.hsize);
    end
  end

  // Next state, bus response, buffer-full stall and final-wait re-read.
  always_comb begin
    state_nxt    = state;
    hready_resp  = 1'b1;
    hresp        = 1'b0;
    stall        = 1'b0;
    reread       = 1'b0;
    wait_cnt_nxt = (wait_cnt != 3'd0) ? wait_cnt - 3'd1 : 3'd0;
    case (state)
      ST_DPH: begin
        // A pending read would take the SRAM port, so hold one cycle to drain.
        stall       = dph_write && wait_cnt == 3'd0 && wb_valid && rd_req;
        hready_resp = (wait_cnt == 3'd0) && !stall;
        reread      = !dph_write && wait_cnt == 3'd1;
      end
      ST_ERR1: begin
        hready_resp = 1'b0;
        hresp       = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
    if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else if (hready_resp) begin
      if (!aph_valid)   state_nxt = ST_IDLE;
      else if (aph_err) state_nxt = ST_ERR1;
      else              state_nxt = ST_DPH;
    end
    if (aph_ok) wait_cnt_nxt = 3'(WAIT_STATES);
  end

  assign wb_fill  = (state == ST_DPH) && dph_write && hready_resp;
  assign wb_flush = wb_valid && !rd_accept && !reread;

  ahbl_sram_wbuf #(.AW(AW)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .fill      (wb_fill),
    .fill_addr (dph_addr),
    .fill_mask (dph_mask),
    .fill_data (ahbls.hwdata),
    .flush     (wb_flush),
    .valid     (wb_valid),
    .addr      (wb_addr),
    .mask      (wb_mask),
    .data      (wb_data),
    .fwd_addr  (dph_addr),
    .fwd_rdata (sram_rdata),
    .fwd_data  (fwd_data)
  );

  // SRAM port arbitration: reads first, buffer drains in any free cycle.
  always_comb begin
    sram_cs    = rd_accept || reread || wb_flush;
    sram_we    = wb_flush;
    sram_addr  = wb_addr;
    if (reread)         sram_addr = dph_addr;
    else if (rd_accept) sram_addr = aph_addr;
    sram_wmask = wb_mask;
    sram_wdata = wb_data;
  end

  assign ahbls.hready_resp = hready_resp;
  assign ahbls.hresp       = hresp;
  assign ahbls.hrdata      = (state == ST_DPH && !dph_write) ? fwd_data : '0;
  assign dbg_state         = state;

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Directed bench for ahbl_sram_responder: zero-wait instance plus a
// two-wait-state instance, each with its own behavioural SRAM.
module tb_ahbl_sram_responder;
  import ahbl_sram_responder_pkg::*;

  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahbl_sram_responder_if #(.W_ADDR(32), .W_DATA(32)) bus ();
  ahbl_sram_responder_if #(.W_ADDR(32), .W_DATA(32)) bus_ws ();
  assign bus.hready    = bus.hready_resp;
  assign bus_ws.hready = bus_ws.hready_resp;

  logic [AW-1:0] sram_addr, ws_sram_addr;
  logic          sram_cs, sram_we, ws_sram_cs, ws_sram_we;
  logic [3:0]    sram_wmask, ws_sram_wmask;
  logic [31:0]   sram_wdata, ws_sram_wdata, sram_rdata, ws_sram_rdata;
  state_t        dbg_state, ws_dbg_state;

  ahbl_sram_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut (
    .clk(clk), .rst(rst), .ahbls(bus.slave),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .dbg_state(dbg_state)
  );

  ahbl_sram_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut_ws (
    .clk(clk), .rst(rst), .ahbls(bus_ws.slave),
    .sram_addr(ws_sram_addr), .sram_cs(ws_sram_cs), .sram_we(ws_sram_we),
    .sram_wmask(ws_sram_wmask), .sram_wdata(ws_sram_wdata), .sram_rdata(ws_sram_rdata),
    .dbg_state(ws_dbg_state)
  );

  // ---------------- SRAM models ----------------
  logic [31:0]   mem    [0:1023];
  logic [31:0]   mem_ws [0:1023];
  logic          pl_we, pl_sel;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  always @(posedge clk) begin
    if (pl_we && !pl_sel) mem[pl_addr] <= pl_data;
    else if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else sram_rdata <= mem[sram_addr];
    end
  end

  always @(posedge clk) begin
    if (pl_we && pl_sel) mem_ws[pl_addr] <= pl_data;
    else if (ws_sram_cs) begin
      if (ws_sram_we) begin
        for (int b = 0; b < 4; b++)
          if (ws_sram_wmask[b]) mem_ws[ws_sram_addr][8*b +: 8] <= ws_sram_wdata[8*b +: 8];
      end else ws_sram_rdata <= mem_ws[ws_sram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_rdata(input string tag);
    exp_v = exp_q.pop_front();
    check(tag, bus.hrdata, exp_v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic aph(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.hwrite = wr;
    bus.hsize = sz;  bus.haddr = a;
  endtask

  task automatic idle();
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
    bus.hsize = HSIZE_WORD; bus.haddr = '0;
  endtask

  task automatic ws_aph(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    bus_ws.hsel = 1'b1; bus_ws.htrans = HTRANS_NONSEQ; bus_ws.hwrite = wr;
    bus_ws.hsize = sz;  bus_ws.haddr = a;
  endtask

  task automatic ws_idle();
    bus_ws.hsel = 1'b0; bus_ws.htrans = HTRANS_IDLE; bus_ws.hwrite = 1'b0;
    bus_ws.hsize = HSIZE_WORD; bus_ws.haddr = '0;
  endtask

  task automatic preload(input logic sel, input logic [AW-1:0] a, input logic [31:0] d);
    pl_sel = sel; pl_addr = a; pl_data = d; pl_we = 1'b1;
    step();
    pl_we = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
    idle(); ws_idle();
    bus.hwdata = '0; bus_ws.hwdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    mid();
    check("rst_hready", 32'(bus.hready_resp), 32'd1);
    check("rst_hresp",  32'(bus.hresp), 32'd0);
    check("rst_hrdata", bus.hrdata, 32'd0);
    check("rst_cs",     32'(sram_cs), 32'd0);
    check("rst_we",     32'(sram_we), 32'd0);
    check("rst_state",  32'(dbg_state), 32'(ST_IDLE));

    // WORD write then back-to-back read of the same word: forwarded
    step(); aph(1'b1, HSIZE_WORD, 32'h10);
    mid();
    check("t1_waph_cs", 32'(sram_cs), 32'd0);
    step(); aph(1'b0, HSIZE_WORD, 32'h10); bus.hwdata = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    mid();
    check("t1_wdph_ready", 32'(bus.hready_resp), 32'd1);
    check("t1_raph_cs",    32'(sram_cs), 32'd1);
    check("t1_raph_we",    32'(sram_we), 32'd0);
    check("t1_raph_addr",  32'(sram_addr), 32'd4);
    step(); idle();
    mid();
    check("t1_rdph_ready", 32'(bus.hready_resp), 32'd1);
    check_rdata("t1_rdata_fwd");
    check("t1_flush_we",    32'(sram_we), 32'd1);
    check("t1_flush_addr",  32'(sram_addr), 32'd4);
    check("t1_flush_wdata", sram_wdata, 32'hDEADBEEF);
    check("t1_flush_mask",  32'(sram_wmask), 32'hF);
    step();
    mid();
    check("t1_we_after", 32'(sram_we), 32'd0);
    check("t1_mem",      mem[4], 32'hDEADBEEF);

    // BYTE write into lane 3, WORD read merges buffer byte over SRAM word
    preload(1'b0, 10'd4, 32'h11223344);
    step(); aph(1'b1, HSIZE_BYTE, 32'h13);
    mid();
    check("t2_waph_ready", 32'(bus.hready_resp), 32'd1);
    step(); aph(1'b0, HSIZE_WORD, 32'h10); bus.hwdata = 32'hAA000000;
    exp_q.push_back(32'hAA223344);
    mid();
    check("t2_raph_cs", 32'(sram_cs), 32'd1);
    check("t2_raph_we", 32'(sram_we), 32'd0);
    step(); idle();
    mid();
    check_rdata("t2_rdata_merge");
    check("t2_flush_we",   32'(sram_we), 32'd1);
    check("t2_flush_mask", 32'(sram_wmask), 32'b1000);
    step();
    mid();
    check("t2_mem", mem[4], 32'hAA223344);

    // W@0 W@4 R@8 pipelined: one stall cycle in W@4 data phase drains W@0
    preload(1'b0, 10'd2, 32'h55667788);
    step(); aph(1'b1, HSIZE_WORD, 32'h0);
    step(); aph(1'b1, HSIZE_WORD, 32'h4); bus.hwdata = 32'h01010101;
    mid();
    check("t3_w0dph_ready", 32'(bus.hready_resp), 32'd1);
    step(); aph(1'b0, HSIZE_WORD, 32'h8); bus.hwdata = 32'h02020202;
    exp_q.push_back(32'h55667788);
    mid();
    check("t3_stall_ready", 32'(bus.hready_resp), 32'd0);
    check("t3_stall_we",    32'(sram_we), 32'd1);
    check("t3_stall_addr",  32'(sram_addr), 32'd0);
    check("t3_stall_wdata", sram_wdata, 32'h01010101);
    check("t3_stall_state", 32'(dbg_state), 32'(ST_DPH));
    step();
    mid();
    check("t3_w4_ready",  32'(bus.hready_resp), 32'd1);
    check("t3_raph_cs",   32'(sram_cs), 32'd1);
    check("t3_raph_we",   32'(sram_we), 32'd0);
    check("t3_raph_addr", 32'(sram_addr), 32'd2);
    step(); idle();
    mid();
    check("t3_rdph_ready", 32'(bus.hready_resp), 32'd1);
    check_rdata("t3_rdata");
    check("t3_flush2_we",    32'(sram_we), 32'd1);
    check("t3_flush2_addr",  32'(sram_addr), 32'd1);
    check("t3_flush2_wdata", sram_wdata, 32'h02020202);
    step();
    mid();
    check("t3_mem0", mem[0], 32'h01010101);
    check("t3_mem1", mem[1], 32'h02020202);

    // Misaligned HALF write: two-cycle ERROR, no SRAM write
    step(); aph(1'b1, HSIZE_HALF, 32'h1);
    mid();
    check("t4_aph_cs", 32'(sram_cs), 32'd0);
    step(); idle();
    mid();
    check("t4_err1_ready", 32'(bus.hready_resp), 32'd0);
    check("t4_err1_hresp", 32'(bus.hresp), 32'd1);
    check("t4_err1_we",    32'(sram_we), 32'd0);
    step();
    mid();
    check("t4_err2_ready", 32'(bus.hready_resp), 32'd1);
    check("t4_err2_hresp", 32'(bus.hresp), 32'd1);
    check("t4_err2_we",    32'(sram_we), 32'd0);
    step();
    mid();
    check("t4_idle_hresp", 32'(bus.hresp), 32'd0);
    check("t4_idle_we",    32'(sram_we), 32'd0);
    check("t4_idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // WAIT_STATES=2 instance: WORD read @0x20
    preload(1'b1, 10'd8, 32'hCAFEF00D);
    step(); ws_aph(1'b0, HSIZE_WORD, 32'h20);
    mid();
    check("t5_aph_ready", 32'(bus_ws.hready_resp), 32'd1);
    check("t5_aph_cs",    32'(ws_sram_cs), 32'd1);
    step(); ws_idle();
    mid();
    check("t5_wait1_ready", 32'(bus_ws.hready_resp), 32'd0);
    check("t5_wait1_hresp", 32'(bus_ws.hresp), 32'd0);
    step();
    mid();
    check("t5_wait2_ready",  32'(bus_ws.hready_resp), 32'd0);
    check("t5_reread_cs",    32'(ws_sram_cs), 32'd1);
    check("t5_reread_we",    32'(ws_sram_we), 32'd0);
    check("t5_reread_addr",  32'(ws_sram_addr), 32'd8);
    step();
    mid();
    check("t5_done_ready", 32'(bus_ws.hready_resp), 32'd1);
    check("t5_done_hresp", 32'(bus_ws.hresp), 32'd0);
    check("t5_done_rdata", bus_ws.hrdata, 32'hCAFEF00D);
    step();
    mid();
    check("t5_idle_ready", 32'(bus_ws.hready_resp), 32'd1);

    // Reset asserted during a buffer-full stall
    preload(1'b0, 10'd16, 32'h600DF00D);
    step(); aph(1'b1, HSIZE_WORD, 32'h40);
    step(); aph(1'b1, HSIZE_WORD, 32'h44); bus.hwdata = 32'h33333333;
    step(); aph(1'b0, HSIZE_WORD, 32'h48); bus.hwdata = 32'h44444444;
    mid();
    check("t6_stall_ready", 32'(bus.hready_resp), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready",  32'(bus.hready_resp), 32'd1);
    check("t6_rst_hresp",  32'(bus.hresp), 32'd0);
    check("t6_rst_hrdata", bus.hrdata, 32'd0);
    check("t6_rst_cs",     32'(sram_cs), 32'd0);
    check("t6_rst_we",     32'(sram_we), 32'd0);
    check("t6_rst_state",  32'(dbg_state), 32'(ST_IDLE));
    step(); idle(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t6_we_after_rst", 32'(sram_we), 32'd0);
      step();
    end
    check("t6_mem_untouched", mem[16], 32'h600DF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
